// File: rtl/invsqrt_pkg.sv
// Shared types and helpers for the inverse-square-root output path.
// Classification works on the 31-bit magnitude word {exponent, mantissa}.
package invsqrt_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    ZERO   = 2'b01,
    INF    = 2'b10,
    NAN    = 2'b11
  } fp_class_t;

  function automatic fp_class_t classify_fp(input logic [30:0] word);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    fp_class_t cls;
    exp_f = word[30:23];
    man_f = word[22:0];
    cls = NORMAL;
    if (exp_f == EXP_MAX) begin
      cls = (man_f == '0) ? INF : NAN;
    end else if (exp_f == '0 && man_f == '0) begin
      cls = ZERO;
    end
    return cls;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic register FIFO with show-ahead read and occupancy outputs.
// count_next exposes the post-edge occupancy so wrappers can register flags from it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   count_next,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // At full a push is only taken when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/invsqrt_out_buffer.sv
// Collects pipeline results, restores the (always positive) sign, classifies and buffers them.
// backprn is registered from the next occupancy so SKID slots remain for in-flight results.
module invsqrt_out_buffer
  import invsqrt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SKID  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [30:0]                  in_data,
  output logic                         backprn,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [31:0]                  m_data,
  output logic [1:0]                   m_class,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - SKID);

  fp_class_t     in_class;
  logic [32:0]   wr_entry;
  logic [32:0]   rd_entry;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          pop;

  assign in_class = classify_fp(in_data);
  assign wr_entry = {in_class, in_data};
  assign m_valid  = !empty;
  assign pop      = m_valid && m_ready;
  assign m_class  = rd_entry[32:31];
  assign m_data   = {1'b0, rd_entry[30:0]};

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .pop        (pop),
    .wdata      (wr_entry),
    .rdata      (rd_entry),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      backprn  <= 1'b1;
    end else begin
      if (in_valid && full && !pop) begin
        overflow <= 1'b1;
      end
      backprn <= !(count_next >= THRESH);
    end
  end

endmodule

// File: tb/tb_invsqrt_out_buffer.sv
// Randomized bench for invsqrt_out_buffer against a queue-based reference model.
module tb_invsqrt_out_buffer;

  localparam int DEPTH = 8;
  localparam int SKID  = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [30:0] in_data;
  logic        backprn;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  m_class;
  logic [3:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] ref_q[$];
  logic        ref_ovf = 1'b0;

  invsqrt_out_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .backprn  (backprn),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_class  (m_class),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ref_class(input logic [30:0] d);
    int e;
    int m;
    e = int'(d[30:23]);
    m = int'(d[22:0]);
    if (e == 255) return (m == 0) ? 2'd2 : 2'd3;
    if (e == 0 && m == 0) return 2'd1;
    return 2'd0;
  endfunction

  // One clock: apply inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [30:0] d, input logic rdy, input logic r);
    bit was_full;
    bit popped;
    in_valid = v;
    in_data  = d;
    m_ready  = rdy;
    rst      = r;
    @(posedge clk);
    if (r) begin
      ref_q.delete();
      ref_ovf = 1'b0;
    end else begin
      was_full = (ref_q.size() == DEPTH);
      popped   = (ref_q.size() != 0) && rdy;
      if (popped) void'(ref_q.pop_front());
      if (v) begin
        if (was_full && !popped) ref_ovf = 1'b1;
        else ref_q.push_back({ref_class(d), d});
      end
    end
    #1;
    chk("m_valid", 32'(m_valid), 32'(ref_q.size() != 0));
    chk("count", 32'(count), 32'(ref_q.size()));
    chk("backprn", 32'(backprn), 32'(ref_q.size() < DEPTH - SKID));
    chk("overflow", 32'(overflow), 32'(ref_ovf));
    if (ref_q.size() != 0) begin
      chk("m_data", m_data, {1'b0, ref_q[0][30:0]});
      chk("m_class", 32'(m_class), 32'(ref_q[0][32:31]));
    end
  endtask

  function automatic logic [30:0] rand_word();
    logic [30:0] w;
    w = 31'($urandom());
    case ($urandom_range(0, 7))
      0: w = 31'h0;
      1: w = 31'h7F800000;
      2: w = 31'h7F800000 | 31'($urandom_range(1, 32'h7FFFFF));
      3: w = 31'($urandom_range(1, 32'h7FFFFF));
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    m_ready  = 1'b0;
    rst      = 1'b1;

    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_backprn", 32'(backprn), 32'd1);

    // single push of 0.5, then pop
    cycle(1, 31'h3F000000, 0, 0);
    chk("single_data", m_data, 32'h3F000000);
    chk("single_class", 32'(m_class), 32'd0);
    cycle(0, '0, 1, 0);
    chk("single_popped", 32'(m_valid), 32'd0);

    // classification sequence
    cycle(1, 31'h00000000, 0, 0);
    cycle(1, 31'h7F800000, 0, 0);
    cycle(1, 31'h7FC00000, 0, 0);
    chk("cls_zero", 32'(m_class), 32'd1);
    cycle(0, '0, 1, 0);
    chk("cls_inf", 32'(m_class), 32'd2);
    cycle(0, '0, 1, 0);
    chk("cls_nan", 32'(m_class), 32'd3);
    chk("cls_sign", 32'(m_data[31]), 32'd0);
    cycle(0, '0, 1, 0);

    // backpressure threshold
    for (int i = 0; i < 4; i++) cycle(1, 31'h3F800000 + 31'(i), 0, 0);
    chk("bp_low", 32'(backprn), 32'd0);
    cycle(0, '0, 1, 0);
    chk("bp_high", 32'(backprn), 32'd1);

    // overflow: fill to 8 then one extra
    cycle(1, '0, 1, 1);
    for (int i = 0; i < 9; i++) cycle(1, 31'h40000000 + 31'(i), 0, 0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", m_data, 32'h40000000 + 32'(i));
      cycle(0, '0, 1, 0);
    end

    // full with simultaneous push and pop
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 31'h41000000 + 31'(i), 0, 0);
    cycle(1, 31'h41ABCDEF, 1, 0);
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0);
    chk("fullpp_tail", m_data, 32'h41ABCDEF);
    cycle(0, '0, 1, 0);

    // reset mid-stream with in_valid high
    for (int i = 0; i < 5; i++) cycle(1, rand_word(), 0, 0);
    cycle(1, 31'h3F000000, 0, 1);
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_bp", 32'(backprn), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), rand_word(),
            1'($urandom_range(0, 3) < (i % 200 < 100 ? 1 : 3)),
            1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
